// File: rtl/uart_rx16_fifo.sv
// 8N1 UART receiver, LSB first, timed by the shared 16x baud enable, feeding a
// first-word-fall-through byte FIFO. Stop-bit failures and full-FIFO drops pulse an error flag.
module uart_rx16_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_in,
  input  logic       en_16_x_baud,
  output logic [7:0] data_out,
  input  logic       buffer_read,
  output logic       buffer_data_present,
  output logic       buffer_half_full,
  output logic       buffer_full,
  output logic       framing_error,
  output logic       overrun
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_HALF = (DEPTH_LOG2 + 1)'(DEPTH / 2);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_e;

  logic                  rx_meta_q, rx_s_q;
  state_e                state_q, state_d;
  logic [3:0]            tick_cnt_q, tick_cnt_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [7:0]            shreg_q, shreg_d;
  logic                  fe_q, fe_d;
  logic                  ov_q, ov_d;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  push, pop;
  logic                  fifo_full;

  // Idle-high reset value keeps a reset release from looking like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= serial_in;
      rx_s_q    <= rx_meta_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      fe_q       <= 1'b0;
      ov_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      fe_q       <= fe_d;
      ov_q       <= ov_d;
    end
  end

  assign fifo_full = (count_q == CNT_FULL);
  assign pop       = buffer_read && (count_q != '0);

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    fe_d       = 1'b0;
    ov_d       = 1'b0;
    push       = 1'b0;
    if (en_16_x_baud) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!rx_s_q) begin
            state_d    = ST_START;
            tick_cnt_d = '0;
          end
        end
        ST_START: begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd7) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = rx_s_q ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            shreg_d   = {rx_s_q, shreg_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = ST_STOP;
          end
        end
        ST_STOP: begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            if (!rx_s_q) begin
              fe_d    = 1'b1;
              state_d = ST_BREAK;
            end else begin
              // A same-cycle pop frees the slot, so a full FIFO can still accept.
              push    = !fifo_full || pop;
              ov_d    = fifo_full && !pop;
              state_d = ST_IDLE;
            end
          end
        end
        ST_BREAK: begin
          if (rx_s_q) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
    end
  end

  // NOTE: the storage array is not reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= shreg_q;
  end

  assign data_out            = mem[rd_ptr_q];
  assign buffer_data_present = (count_q != '0);
  assign buffer_half_full    = (count_q >= CNT_HALF);
  assign buffer_full         = fifo_full;
  assign framing_error       = fe_q;
  assign overrun             = ov_q;

endmodule

// File: tb/tb_uart_rx16_fifo.sv
// Directed bench for uart_rx16_fifo: a queue model of the byte buffer is checked every cycle,
// plus literal expectations for each scenario.
module tb_uart_rx16_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       serial_in = 1'b1;
  logic       en_16_x_baud = 1'b0;
  logic       buffer_read = 1'b0;
  logic [7:0] data_out;
  logic       buffer_data_present;
  logic       buffer_half_full;
  logic       buffer_full;
  logic       framing_error;
  logic       overrun;

  uart_rx16_fifo #(.DEPTH_LOG2(4)) dut (
    .clk                 (clk),
    .reset               (reset),
    .serial_in           (serial_in),
    .en_16_x_baud        (en_16_x_baud),
    .data_out            (data_out),
    .buffer_read         (buffer_read),
    .buffer_data_present (buffer_data_present),
    .buffer_half_full    (buffer_half_full),
    .buffer_full         (buffer_full),
    .framing_error       (framing_error),
    .overrun             (overrun)
  );

  initial forever #5 clk = ~clk;

  // Baud enable: one clk high out of every four.
  initial forever begin
    repeat (3) @(negedge clk);
    en_16_x_baud = 1'b1;
    @(negedge clk);
    en_16_x_baud = 1'b0;
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Model: the FIFO is a queue; a frame's outcome is decided on its stop-sample tick.
  logic [7:0] model_q[$];
  logic [7:0] cur_byte = 8'h00;
  bit         stop_arm = 1'b0;
  bit         stop_val = 1'b1;
  bit         exp_fe = 1'b0;
  bit         exp_ov = 1'b0;
  bit         cmp_en = 1'b0;
  int         fe_seen = 0;
  int         ov_seen = 0;

  always @(posedge clk) begin
    if (reset) begin
      model_q.delete();
      exp_fe   = 1'b0;
      exp_ov   = 1'b0;
      stop_arm = 1'b0;
    end else begin
      exp_fe = 1'b0;
      exp_ov = 1'b0;
      if (buffer_read && model_q.size() != 0) void'(model_q.pop_front());
      if (stop_arm && en_16_x_baud) begin
        stop_arm = 1'b0;
        if (!stop_val)                exp_fe = 1'b1;
        else if (model_q.size() < DEPTH) model_q.push_back(cur_byte);
        else                          exp_ov = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("present", buffer_data_present, model_q.size() != 0);
      check("half_full", buffer_half_full, model_q.size() >= DEPTH / 2);
      check("full", buffer_full, model_q.size() == DEPTH);
      check("framing_error", framing_error, exp_fe);
      check("overrun", overrun, exp_ov);
      if (model_q.size() != 0) check("data_out", data_out, model_q[0]);
      if (framing_error) fe_seen++;
      if (overrun) ov_seen++;
    end
  end

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!en_16_x_baud) @(posedge clk);
    end
  endtask

  // Start edge is driven just after tick 0; the DUT samples the stop bit on tick 153.
  task automatic send_frame(input logic [7:0] d, input logic stop, input bit rd_at_stop);
    wait_ticks(4);
    cur_byte = d;
    stop_val = stop;
    #1 serial_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wait_ticks(16);
      #1 serial_in = d[i];
    end
    wait_ticks(16);
    #1 serial_in = stop;
    wait_ticks(8);
    #1 stop_arm = 1'b1;
    if (rd_at_stop) begin
      repeat (3) @(posedge clk);
      #1 buffer_read = 1'b1;
      @(posedge clk);
      #1 buffer_read = 1'b0;
    end
    wait_ticks(7);
  endtask

  task automatic read_byte(output logic [7:0] d);
    @(posedge clk);
    #1 d = data_out;
    buffer_read = 1'b1;
    @(posedge clk);
    #1 buffer_read = 1'b0;
  endtask

  logic [7:0] rd_byte;
  int         base;

  initial begin
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    cmp_en = 1'b1;
    check("reset present", buffer_data_present, 1'b0);
    check("reset half_full", buffer_half_full, 1'b0);
    check("reset full", buffer_full, 1'b0);
    check("reset framing_error", framing_error, 1'b0);
    check("reset overrun", overrun, 1'b0);

    // 1: single good frame
    send_frame(8'hA5, 1'b1, 1'b0);
    check("t1 present", buffer_data_present, 1'b1);
    check("t1 data_out", data_out, 8'hA5);
    read_byte(rd_byte);
    check("t1 read", rd_byte, 8'hA5);
    check("t1 empty", buffer_data_present, 1'b0);

    // 2: short low glitch
    base = fe_seen;
    wait_ticks(4);
    #1 serial_in = 1'b0;
    wait_ticks(3);
    #1 serial_in = 1'b1;
    wait_ticks(24);
    check("t2 no push", buffer_data_present, 1'b0);
    check("t2 no framing", fe_seen - base, 0);

    // 3: bad stop bit, line held low, then a good frame
    base = fe_seen;
    send_frame(8'h3C, 1'b0, 1'b0);
    wait_ticks(40);
    #1 serial_in = 1'b1;
    send_frame(8'h81, 1'b1, 1'b0);
    check("t3 framing pulses", fe_seen - base, 1);
    check("t3 data_out", data_out, 8'h81);
    read_byte(rd_byte);
    check("t3 read", rd_byte, 8'h81);
    check("t3 empty", buffer_data_present, 1'b0);

    // 4: fill past full with no reads
    base = ov_seen;
    for (int i = 0; i < 17; i++) begin
      send_frame(8'(i), 1'b1, 1'b0);
      if (i == 6)  check("t4 half_full after 7", buffer_half_full, 1'b0);
      if (i == 7)  check("t4 half_full after 8", buffer_half_full, 1'b1);
      if (i == 14) check("t4 full after 15", buffer_full, 1'b0);
      if (i == 15) check("t4 full after 16", buffer_full, 1'b1);
    end
    check("t4 overrun pulses", ov_seen - base, 1);
    for (int i = 0; i < 16; i++) begin
      read_byte(rd_byte);
      check($sformatf("t4 read %0d", i), rd_byte, 8'(i));
    end
    check("t4 empty", buffer_data_present, 1'b0);

    // 5: reset in the middle of a frame, with a byte already buffered
    send_frame(8'h42, 1'b1, 1'b0);
    check("t5 preload", buffer_data_present, 1'b1);
    wait_ticks(4);
    #1 serial_in = 1'b0;
    wait_ticks(16);
    #1 serial_in = 1'b1;
    wait_ticks(60);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("t5 present", buffer_data_present, 1'b0);
    check("t5 half_full", buffer_half_full, 1'b0);
    check("t5 full", buffer_full, 1'b0);
    check("t5 framing_error", framing_error, 1'b0);
    check("t5 overrun", overrun, 1'b0);
    wait_ticks(120);
    check("t5 no partial push", buffer_data_present, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b0);
    check("t5 data_out", data_out, 8'h5A);
    read_byte(rd_byte);
    check("t5 read", rd_byte, 8'h5A);

    // 6: full FIFO, pop coincident with push
    for (int i = 0; i < 16; i++) send_frame(8'h20 + 8'(i), 1'b1, 1'b0);
    check("t6 full before", buffer_full, 1'b1);
    base = ov_seen;
    send_frame(8'h77, 1'b1, 1'b1);
    check("t6 full after", buffer_full, 1'b1);
    check("t6 no overrun", ov_seen - base, 0);
    for (int i = 1; i < 16; i++) begin
      read_byte(rd_byte);
      check($sformatf("t6 read %0d", i), rd_byte, 8'h20 + 8'(i));
    end
    read_byte(rd_byte);
    check("t6 last read", rd_byte, 8'h77);
    check("t6 empty", buffer_data_present, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: still running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
